invert: RTL and testbench

//  Bit-serial two's-complement negator, LSB first.
//  - Copies each input bit to the output up to and including the first '1'.
//  - Inverts every later bit.
//  - Sits between a serial source and a serial sink in the datapath.
//  - Streams with zero latency: each output bit is valid in the same cycle as its input bit.

---
 rtl/invert_pkg.sv | 9 +
 rtl/invert.sv | 65 ++++++
 tb/tb_invert.sv | 115 +++++++++++
 3 files changed

// File: rtl/invert_pkg.sv
// Shared definitions for the bit-serial two's-complement negator.
package invert_pkg;

    typedef enum logic {
        PASS   = 1'b0,
        INVERT = 1'b1
    } state_t;

endpackage

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first, zero latency (Mealy output).
// Optional auto re-arm every FRAME_BITS bits; FRAME_BITS==0 leaves only reset to re-arm.
module invert
    import invert_pkg::*;
#(
    parameter int FRAME_BITS = 0
) (
    input  logic i,
    input  logic rst_n,
    input  logic clk,
    output logic y
);

    state_t state;
    state_t state_next;
    logic   frame_end;

    if (FRAME_BITS < 0) begin : g_bad_param
        $error("invert: FRAME_BITS must be >= 0, got %0d", FRAME_BITS);
    end

    // Frame end overrides the PASS->INVERT transition on the same edge.
    always_comb begin
        state_next = state;
        if (frame_end) begin
            state_next = PASS;
        end else if (state == PASS && i) begin
            state_next = INVERT;
        end
    end

    assign y = (state == INVERT) ? ~i : i;

    generate
        if (FRAME_BITS > 0) begin : g_framed
            localparam int              CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
            localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_BITS - 1);

            logic [CNT_W-1:0] bit_cnt;

            assign frame_end = (bit_cnt == LAST);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state   <= PASS;
                    bit_cnt <= '0;
                end else begin
                    state   <= state_next;
                    bit_cnt <= frame_end ? '0 : bit_cnt + CNT_W'(1);
                end
            end
        end else begin : g_unframed
            assign frame_end = 1'b0;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state <= PASS;
                end else begin
                    state <= state_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_invert.sv
// Self-checking bench for invert: unframed, 4-bit framed and 8-bit framed instances.
module tb_invert;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i0 = 1'b0, r0 = 1'b0, y0;
    logic i1 = 1'b0, r1 = 1'b0, y1;
    logic i2 = 1'b0, r2 = 1'b0, y2;

    int vectors     = 0;
    int miscompares = 0;

    invert #(.FRAME_BITS(0)) dut0 (.i(i0), .rst_n(r0), .clk(clk), .y(y0));
    invert #(.FRAME_BITS(4)) dut1 (.i(i1), .rst_n(r1), .clk(clk), .y(y1));
    invert #(.FRAME_BITS(8)) dut2 (.i(i2), .rst_n(r2), .clk(clk), .y(y2));

    // Drive one cycle's inputs on the given instance, then check y before the next rising edge.
    task automatic step(input int unit, input logic b, input logic r, input logic exp, input string tag);
        logic obs;
        @(negedge clk);
        case (unit)
            0:       begin i0 = b; r0 = r; end
            1:       begin i1 = b; r1 = r; end
            default: begin i2 = b; r2 = r; end
        endcase
        #1;
        obs = (unit == 0) ? y0 : (unit == 1) ? y1 : y2;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: y=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle without checking (used before state is defined).
    task automatic drive(input int unit, input logic b, input logic r);
        @(negedge clk);
        case (unit)
            0:       begin i0 = b; r0 = r; end
            1:       begin i1 = b; r1 = r; end
            default: begin i2 = b; r2 = r; end
        endcase
    endtask

    // Feed a 4-bit LSB-first pattern and check against expected bits.
    task automatic word4(input int unit, input logic [3:0] bits, input logic [3:0] exp, input string tag);
        for (int k = 0; k < 4; k++) begin
            step(unit, bits[k], 1'b1, exp[k], $sformatf("%s[%0d]", tag, k));
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] neg;
        int         rst_word;
        int         rst_bit;
        logic       rb;
        logic       seen;

        // ---------- Unframed instance ----------
        drive(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, "reset_i0");
        step(0, 1'b1, 1'b0, 1'b1, "reset_i1");
        step(0, 1'b1, 1'b0, 1'b1, "reset_hold_pass");

        // 6 -> 10 (-6 mod 16)
        word4(0, 4'b0110, 4'b1010, "word6");

        drive(0, 1'b0, 1'b0);
        word4(0, 4'b0000, 4'b0000, "word0");
        step(0, 1'b1, 1'b1, 1'b1, "word0_still_pass");

        // Mid-word reset
        drive(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1, "midrst_a0");
        step(0, 1'b0, 1'b1, 1'b1, "midrst_a1");
        step(0, 1'b0, 1'b0, 1'b1, "midrst_rst");
        step(0, 1'b0, 1'b1, 1'b0, "midrst_b0");
        step(0, 1'b1, 1'b1, 1'b1, "midrst_b1");
        step(0, 1'b0, 1'b1, 1'b1, "midrst_b2");

        // ---------- FRAME_BITS=4 instance ----------
        drive(1, 1'b0, 1'b0);
        word4(1, 4'b0110, 4'b1010, "f4_word6");
        word4(1, 4'b0001, 4'b1111, "f4_word1_rearm");
        word4(1, 4'b1000, 4'b1000, "f4_mostneg");
        word4(1, 4'b0100, 4'b1100, "f4_after_last1");
        word4(1, 4'b0000, 4'b0000, "f4_zero");

        // ---------- FRAME_BITS=8 random words ----------
        drive(2, 1'b0, 1'b0);
        rst_word = int'($urandom_range(20, 180));
        rst_bit  = int'($urandom_range(1, 7));
        for (int n = 0; n < 200; n++) begin
            w   = 8'($urandom);
            neg = (~w + 8'd1) & 8'hFF;
            for (int k = 0; k < 8; k++) begin
                if (n == rst_word && k == rst_bit) begin
                    // Reset cycle: output still reflects whether a 1 was seen so far.
                    rb   = 1'($urandom);
                    seen = ((w & ((8'd1 << rst_bit) - 8'd1)) != 8'd0);
                    step(2, rb, 1'b0, seen ? ~rb : rb, $sformatf("rand_rst_w%0d", n));
                    break;
                end
                step(2, w[k], 1'b1, neg[k], $sformatf("rand_w%0d_b%0d", n, k));
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
